// File: rtl/video_pkg.sv
// Shared video types and default geometry for the pixel RAM family.
package video_pkg;

  localparam int unsigned DEF_ADDR_W   = 20;
  localparam int unsigned DEF_CHANNELS = 3;
  localparam int unsigned DEF_CH_W     = 8;

  typedef logic [DEF_CHANNELS-1:0][DEF_CH_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fill_state_t;

endpackage

// File: rtl/vram_core.sv
// Simple dual-port pixel array: per-channel masked write, read-first registered read.
module vram_core #(
  parameter int unsigned ADDR_W   = 20,
  parameter int unsigned DEPTH    = 1 << ADDR_W,
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned CH_W     = 8
) (
  input  logic                       clk_i,
  input  logic                       we_i,
  input  logic [CHANNELS-1:0]        wmask_i,
  input  logic [ADDR_W-1:0]          waddr_i,
  input  logic [CHANNELS*CH_W-1:0]   wdata_i,
  input  logic                       re_i,
  input  logic [ADDR_W-1:0]          raddr_i,
  output logic [CHANNELS*CH_W-1:0]   rdata_o
);

  localparam int unsigned PIX_W = CHANNELS * CH_W;

  logic [PIX_W-1:0] mem_q [DEPTH];
  logic [PIX_W-1:0] rdata_q;

  // Read samples the array before this edge's write lands, giving read-first collisions.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        if (wmask_i[c]) begin
          mem_q[waddr_i][c*CH_W +: CH_W] <= wdata_i[c*CH_W +: CH_W];
        end
      end
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  always_comb rdata_o = rdata_q;

endmodule

// File: rtl/frame_buffer_ram.sv
// Frame buffer: bounds-checked user port, constant-colour fill engine and
// configurable read latency with a valid strobe around a vram_core array.
module frame_buffer_ram
  import video_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned DEPTH    = 1 << ADDR_W,
  parameter int unsigned CHANNELS = DEF_CHANNELS,
  parameter int unsigned CH_W     = DEF_CH_W,
  parameter int unsigned READ_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      writeEn,
  input  logic [CHANNELS-1:0]       writeMask,
  input  logic [ADDR_W-1:0]         writePointer,
  input  logic [CHANNELS*CH_W-1:0]  dataIn,
  input  logic                      readEn,
  input  logic [ADDR_W-1:0]         readPointer,
  output logic [CHANNELS*CH_W-1:0]  dataOut,
  output logic                      readValid,
  input  logic                      fillStart,
  input  logic [CHANNELS*CH_W-1:0]  fillValue,
  output logic                      fillBusy,
  output logic                      fillDone,
  output logic                      writeDrop
);

  localparam int unsigned PIX_W = CHANNELS * CH_W;
  localparam int unsigned AW1   = ADDR_W + 1;
  localparam logic [ADDR_W:0]   DEPTH_L = AW1'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  fill_state_t         state_q, state_d;
  logic [ADDR_W-1:0]   fcnt_q, fcnt_d;
  logic [PIX_W-1:0]    fval_q, fval_d;
  logic                drop_q, drop_d;
  logic [READ_LAT-1:0] vld_q;
  logic                rng_q;
  logic [PIX_W-1:0]    hold_q;

  logic                wr_in_range, rd_in_range, user_ok;
  logic                core_we, core_re;
  logic [CHANNELS-1:0] core_mask;
  logic [ADDR_W-1:0]   core_waddr;
  logic [PIX_W-1:0]    core_wdata, core_rdata;
  logic [PIX_W-1:0]    pix0, out_pix;
  logic                out_vld;

  always_comb begin
    wr_in_range = {1'b0, writePointer} < DEPTH_L;
    rd_in_range = {1'b0, readPointer} < DEPTH_L;
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    fval_d  = fval_q;
    unique case (state_q)
      IDLE: begin
        if (fillStart) begin
          state_d = FILL;
          fcnt_d  = '0;
          fval_d  = fillValue;
        end
      end
      FILL: begin
        if (fcnt_q == LAST) begin
          state_d = DONE;
        end else begin
          fcnt_d = fcnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Fill owns the write port whenever it runs; user writes are only honoured in IDLE.
  always_comb begin
    user_ok    = writeEn && (state_q == IDLE) && wr_in_range;
    drop_d     = writeEn && ((state_q != IDLE) || !wr_in_range);
    core_we    = !rst && ((state_q == FILL) || user_ok);
    core_waddr = (state_q == FILL) ? fcnt_q : writePointer;
    core_mask  = (state_q == FILL) ? '1 : writeMask;
    core_wdata = (state_q == FILL) ? fval_q : dataIn;
    core_re    = readEn && rd_in_range;
  end

  vram_core #(
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .CHANNELS (CHANNELS),
    .CH_W     (CH_W)
  ) u_core (
    .clk_i   (clk),
    .we_i    (core_we),
    .wmask_i (core_mask),
    .waddr_i (core_waddr),
    .wdata_i (core_wdata),
    .re_i    (core_re),
    .raddr_i (readPointer),
    .rdata_o (core_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      fcnt_q  <= '0;
      fval_q  <= '0;
      drop_q  <= 1'b0;
      vld_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      fval_q  <= fval_d;
      drop_q  <= drop_d;
      vld_q   <= (vld_q << 1) | READ_LAT'(readEn);
      hold_q  <= dataOut;
    end
  end

  always_ff @(posedge clk) begin
    rng_q <= rd_in_range;
  end

  always_comb pix0 = rng_q ? core_rdata : '0;

  // Core supplies the first latency cycle; extra cycles are a plain data shift line
  // kept in step with the valid shift register.
  if (READ_LAT == 1) begin : g_lat1
    always_comb out_pix = pix0;
  end else begin : g_latn
    localparam int unsigned SR_W = (READ_LAT - 1) * PIX_W;
    logic [SR_W-1:0] sr_q;
    always_ff @(posedge clk) begin
      sr_q <= (sr_q << PIX_W) | SR_W'(pix0);
    end
    always_comb out_pix = sr_q[SR_W-1 -: PIX_W];
  end

  always_comb begin
    out_vld   = vld_q[READ_LAT-1];
    readValid = out_vld;
    dataOut   = out_vld ? out_pix : hold_q;
    fillBusy  = (state_q == FILL);
    fillDone  = (state_q == DONE);
    writeDrop = drop_q;
  end

endmodule

// File: tb/tb_frame_buffer_ram.sv
// Scoreboard bench: two frame buffers (16 deep/latency 1, 10 deep/latency 3)
// share stimulus and are each checked against a behavioural model.
module tb_frame_buffer_ram;

  localparam int D0 = 16;
  localparam int L0 = 1;
  localparam int D1 = 10;
  localparam int L1 = 3;

  logic        clk;
  logic        rst;
  logic        writeEn;
  logic [2:0]  writeMask;
  logic [4:0]  writePointer;
  logic [23:0] dataIn;
  logic        readEn;
  logic [4:0]  readPointer;
  logic        fillStart;
  logic [23:0] fillValue;

  logic [23:0] dout0, dout1;
  logic        rv0, rv1, busy0, busy1, done0, done1, drop0, drop1;

  frame_buffer_ram #(
    .ADDR_W (5), .DEPTH (D0), .CHANNELS (3), .CH_W (8), .READ_LAT (L0)
  ) dut0 (
    .clk (clk), .rst (rst), .writeEn (writeEn), .writeMask (writeMask),
    .writePointer (writePointer), .dataIn (dataIn), .readEn (readEn),
    .readPointer (readPointer), .dataOut (dout0), .readValid (rv0),
    .fillStart (fillStart), .fillValue (fillValue), .fillBusy (busy0),
    .fillDone (done0), .writeDrop (drop0)
  );

  frame_buffer_ram #(
    .ADDR_W (5), .DEPTH (D1), .CHANNELS (3), .CH_W (8), .READ_LAT (L1)
  ) dut1 (
    .clk (clk), .rst (rst), .writeEn (writeEn), .writeMask (writeMask),
    .writePointer (writePointer), .dataIn (dataIn), .readEn (readEn),
    .readPointer (readPointer), .dataOut (dout1), .readValid (rv1),
    .fillStart (fillStart), .fillValue (fillValue), .fillBusy (busy1),
    .fillDone (done1), .writeDrop (drop1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [23:0] d;
  } rd_t;

  rd_t         q0[$];
  rd_t         q1[$];
  logic [23:0] mem [2][32];
  bit          active [2];
  bit          dpend  [2];
  int          fa     [2];
  logic [23:0] fv     [2];
  bit          e_busy [2];
  bit          e_done [2];
  bit          e_drop [2];
  logic [23:0] last   [2];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d cyc%0d: got %h expected %h", name, k, cyc, act, exp);
    end
  endtask

  // Reference model: a memory array, a "fill in progress at address fa" flag,
  // a pending done pulse, and a queue of reads tagged with the cycle they are due.
  task automatic model_step(input int k);
    int  dk;
    int  lk;
    bit  idle;
    rd_t r;
    dk = (k == 0) ? D0 : D1;
    lk = (k == 0) ? L0 : L1;
    if (rst) begin
      active[k] = 0; dpend[k] = 0;
      e_busy[k] = 0; e_done[k] = 0; e_drop[k] = 0;
      last[k] = '0;
      if (k == 0) q0.delete(); else q1.delete();
      return;
    end
    if (readEn) begin
      r.due = cyc + lk - 1;
      r.d   = (int'(readPointer) < dk) ? mem[k][readPointer] : 24'h0;
      if (k == 0) q0.push_back(r); else q1.push_back(r);
    end
    idle = !active[k] && !dpend[k];
    e_drop[k] = writeEn && (!idle || int'(writePointer) >= dk);
    if (writeEn && idle && int'(writePointer) < dk) begin
      for (int c = 0; c < 3; c++)
        if (writeMask[c]) mem[k][writePointer][c*8 +: 8] = dataIn[c*8 +: 8];
    end
    if (active[k]) begin
      mem[k][fa[k]] = fv[k];
      if (fa[k] == dk - 1) begin
        active[k] = 0;
        dpend[k]  = 1;
      end else begin
        fa[k]++;
      end
    end else if (dpend[k]) begin
      dpend[k] = 0;
    end else if (fillStart) begin
      active[k] = 1;
      fa[k]     = 0;
      fv[k]     = fillValue;
    end
    e_busy[k] = active[k];
    e_done[k] = dpend[k];
  endtask

  always @(posedge clk) begin
    cyc++;
    model_step(0);
    model_step(1);
  end

  task automatic mon(input int k, input logic rv, input logic [23:0] dout,
                     input logic busy, input logic done, input logic drop);
    bit  expv;
    rd_t r;
    expv = 0;
    if (k == 0) begin
      if (q0.size() > 0 && q0[0].due == cyc) begin expv = 1; r = q0.pop_front(); end
    end else begin
      if (q1.size() > 0 && q1[0].due == cyc) begin expv = 1; r = q1.pop_front(); end
    end
    chk("readValid", k, {31'b0, rv}, {31'b0, expv});
    if (expv) last[k] = r.d;
    chk("dataOut", k, {8'b0, dout}, {8'b0, last[k]});
    chk("fillBusy", k, {31'b0, busy}, {31'b0, e_busy[k]});
    chk("fillDone", k, {31'b0, done}, {31'b0, e_done[k]});
    chk("writeDrop", k, {31'b0, drop}, {31'b0, e_drop[k]});
  endtask

  always @(posedge clk) begin
    #1;
    mon(0, rv0, dout0, busy0, done0, drop0);
    mon(1, rv1, dout1, busy1, done1, drop1);
  end

  task automatic clear_inputs();
    writeEn = 0; writeMask = '0; writePointer = '0; dataIn = '0;
    readEn = 0; readPointer = '0; fillStart = 0; fillValue = '0;
  endtask

  task automatic idle(input int n);
    clear_inputs();
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input bit we, input logic [2:0] m, input logic [4:0] wp,
                       input logic [23:0] d, input bit re, input logic [4:0] rp,
                       input bit fs, input logic [23:0] fvl);
    writeEn = we; writeMask = m; writePointer = wp; dataIn = d;
    readEn = re; readPointer = rp; fillStart = fs; fillValue = fvl;
    @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] m, input logic [4:0] wp, input logic [23:0] d);
    drive(1, m, wp, d, 0, '0, 0, '0);
  endtask

  task automatic rd(input logic [4:0] rp);
    drive(0, '0, '0, '0, 1, rp, 0, '0);
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;

    // Initial fill so every in-range word is known.
    drive(0, '0, '0, '0, 0, '0, 1, 24'h123456);
    idle(20);

    wr(3'b111, 5'h10, 24'hA1B2C3);
    rd(5'h10);
    idle(4);

    wr(3'b111, 5'd5, 24'h112233);
    wr(3'b010, 5'd5, 24'hAABBCC);
    rd(5'd5);
    idle(4);

    for (int i = 0; i < 8; i++) rd(5'(i));
    idle(5);

    drive(0, '0, '0, '0, 0, '0, 1, 24'h00FF00);
    wr(3'b111, 5'd2, 24'hDEAD00);
    idle(20);
    for (int i = 0; i < 16; i++) rd(5'(i));
    idle(5);

    for (int i = 0; i < 16; i++) wr(3'b111, 5'(i), 24'h100000 | 24'(i));
    drive(0, '0, '0, '0, 0, '0, 1, 24'hC0FFEE);
    idle(5);
    rst = 1;
    idle(1);
    rst = 0;
    idle(2);
    for (int i = 0; i < 16; i++) rd(5'(i));
    idle(5);

    wr(3'b111, 5'd12, 24'h777777);
    rd(5'd12);
    rd(5'd25);
    wr(3'b111, 5'd3, 24'h010203);
    drive(1, 3'b111, 5'd3, 24'h0A0B0C, 1, 5'd3, 0, '0);
    rd(5'd3);
    idle(4);

    drive(1, 3'b111, 5'd1, 24'h555555, 0, '0, 1, 24'h0000AA);
    idle(20);
    rd(5'd1);
    wr(3'b000, 5'd1, 24'hFFFFFF);
    rd(5'd1);
    idle(4);

    for (int i = 0; i < 400; i++) begin
      drive(bit'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            5'($urandom_range(0, 31)), 24'($urandom),
            bit'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
            ($urandom_range(0, 59) == 0), 24'($urandom));
    end
    idle(25);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
